receive_shift: RTL and testbench

- Serial-to-parallel receive path of the USB endpoint. It is the counterpart of the transmit-side parallel-to-serial shifter.
- Takes the NRZI-decoded bit stream plus a per-bit sample strobe from the receive front end.
- Hunts SYNC, strips stuffed bits, assembles LSB-first bytes, and hands each byte to the receive FIFO/AES input with a one-cycle valid pulse.
- Flags bit-stuff violations and partial bytes at EOP.

---
 rtl/rx_pkg.sv | 20 ++
 rtl/flex_stp_sr.sv | 46 ++++
 rtl/receive_shift.sv | 186 ++++++++++++++++++
 tb/tb_receive_shift.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_pkg.sv
// Shared definitions for the USB receive shifter.
// Contents:
//   rx_state_t          - receive FSM states
//   SYNC_PATTERN        - hunt register value after a full SYNC (LSB-first arrival 0000_0001)
//   DEFAULT_DATA_WIDTH  - default bits per assembled byte
//   DEFAULT_STUFF_LIMIT - default run of 1s after which a stuff bit follows
package rx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RECEIVE,
    STUFF,
    ERROR
  } rx_state_t;

  localparam logic [7:0]  SYNC_PATTERN        = 8'h80;
  localparam int unsigned DEFAULT_DATA_WIDTH  = 8;
  localparam int unsigned DEFAULT_STUFF_LIMIT = 6;

endpackage

// File: rtl/flex_stp_sr.sv
// Flexible serial-to-parallel shift register.
// Parameters:
//   NUM_BITS  - register width (>= 2)
//   SHIFT_MSB - 1: shift toward MSB, new bit enters LSB
//               0: shift toward LSB, new bit enters MSB (LSB-first serial streams)
// Ports:
//   clk            - clock
//   rst            - asynchronous active-high reset (clears register)
//   shift_enable_i - shift one bit in this cycle
//   serial_in_i    - incoming bit
//   parallel_out_o - current register contents
module flex_stp_sr #(
  parameter int unsigned NUM_BITS  = 8,
  parameter bit          SHIFT_MSB = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                shift_enable_i,
  input  logic                serial_in_i,
  output logic [NUM_BITS-1:0] parallel_out_o
);

  logic [NUM_BITS-1:0] sr_q, sr_d;

  always_comb begin
    sr_d = sr_q;
    if (shift_enable_i) begin
      if (SHIFT_MSB) begin
        sr_d = {sr_q[NUM_BITS-2:0], serial_in_i};
      end else begin
        sr_d = {serial_in_i, sr_q[NUM_BITS-1:1]};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign parallel_out_o = sr_q;

endmodule

// File: rtl/receive_shift.sv
// USB receive path: serial-to-parallel shifter with SYNC hunt and bit-stuff removal.
// Build option:
//   RX_SYNC_HUNT_EN defined   - IDLE hunts for the SYNC pattern before receiving.
//   RX_SYNC_HUNT_EN undefined - first strobe in IDLE starts the packet as data bit 0
//                               (SYNC, if present, is delivered as the first byte).
// Ports:
//   clk            - system clock
//   rst            - asynchronous active-high reset
//   serial_in_i    - NRZI-decoded bit, valid when shift_strobe_i=1
//   shift_strobe_i - one-cycle pulse per received bit period
//   eop_i          - end of packet from the front end (level)
//   rx_data_o      - last completed byte, held until the next one completes
//   byte_valid_o   - one-cycle pulse when rx_data_o is updated
//   receiving_o    - high from packet start until EOP or stuff error
//   stuff_err_o    - sticky stuff violation flag, cleared at next packet start
//   eop_err_o      - one-cycle pulse: EOP with a partial byte pending
module receive_shift
  import rx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int unsigned STUFF_LIMIT = DEFAULT_STUFF_LIMIT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  serial_in_i,
  input  logic                  shift_strobe_i,
  input  logic                  eop_i,
  output logic [DATA_WIDTH-1:0] rx_data_o,
  output logic                  byte_valid_o,
  output logic                  receiving_o,
  output logic                  stuff_err_o,
  output logic                  eop_err_o
);

  localparam int unsigned BitCntW  = $clog2(DATA_WIDTH);
  localparam int unsigned OnesCntW = $clog2(STUFF_LIMIT + 1);

  localparam logic [BitCntW-1:0]  LastBit    = BitCntW'(DATA_WIDTH - 1);
  localparam logic [OnesCntW-1:0] StuffLimit = OnesCntW'(STUFF_LIMIT);

  rx_state_t             state_q;
  logic [BitCntW-1:0]    bit_cnt_q;
  logic [OnesCntW-1:0]   ones_cnt_q;
  logic [DATA_WIDTH-1:0] rx_data_q;
  logic                  byte_valid_q;
  logic                  receiving_q;
  logic                  stuff_err_q;
  logic                  eop_err_q;

`ifdef RX_SYNC_HUNT_EN
  logic [7:0] hunt_q;
  logic [7:0] hunt_next;
`endif

  // Only the first DATA_WIDTH-1 bits are stored; the completing bit comes straight
  // from serial_in_i so the byte can be registered on the same edge.
  logic [DATA_WIDTH-2:0] sr_par;
  logic [DATA_WIDTH-1:0] byte_asm;
  logic [OnesCntW-1:0]   ones_next;
  logic                  data_bit;
  logic                  shift_en;

  always_comb begin
    data_bit = 1'b0;
    if (shift_strobe_i && !eop_i) begin
      unique case (state_q)
        RECEIVE: data_bit = 1'b1;
`ifdef RX_SYNC_HUNT_EN
        IDLE:    data_bit = 1'b0;
`else
        IDLE:    data_bit = 1'b1;
`endif
        default: data_bit = 1'b0;
      endcase
    end
  end

  // The completing bit of a byte is never stored, so suppress that shift.
  assign shift_en  = data_bit && !(state_q == RECEIVE && bit_cnt_q == LastBit);
  assign byte_asm  = {serial_in_i, sr_par};
  assign ones_next = serial_in_i ? ones_cnt_q + 1'b1 : '0;

`ifdef RX_SYNC_HUNT_EN
  assign hunt_next = {serial_in_i, hunt_q[7:1]};
`endif

  flex_stp_sr #(
    .NUM_BITS  (DATA_WIDTH - 1),
    .SHIFT_MSB (1'b0)
  ) u_data_sr (
    .clk            (clk),
    .rst            (rst),
    .shift_enable_i (shift_en),
    .serial_in_i    (serial_in_i),
    .parallel_out_o (sr_par)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      ones_cnt_q   <= '0;
      rx_data_q    <= '0;
      byte_valid_q <= 1'b0;
      receiving_q  <= 1'b0;
      stuff_err_q  <= 1'b0;
      eop_err_q    <= 1'b0;
`ifdef RX_SYNC_HUNT_EN
      hunt_q       <= '0;
`endif
    end else begin
      byte_valid_q <= 1'b0;
      eop_err_q    <= 1'b0;
      if (eop_i) begin
        // EOP beats a coincident strobe: that bit (and any byte it completes) is dropped.
        if ((state_q == RECEIVE || state_q == STUFF) && bit_cnt_q != '0) begin
          eop_err_q <= 1'b1;
        end
        state_q     <= IDLE;
        receiving_q <= 1'b0;
        bit_cnt_q   <= '0;
        ones_cnt_q  <= '0;
`ifdef RX_SYNC_HUNT_EN
        hunt_q      <= '0;
`endif
      end else if (shift_strobe_i) begin
        unique case (state_q)
          IDLE: begin
`ifdef RX_SYNC_HUNT_EN
            if (hunt_next == SYNC_PATTERN) begin
              state_q     <= RECEIVE;
              receiving_q <= 1'b1;
              stuff_err_q <= 1'b0;
              bit_cnt_q   <= '0;
              // The trailing 1 of SYNC counts toward the first stuff run.
              ones_cnt_q  <= OnesCntW'(1);
              hunt_q      <= '0;
            end else begin
              hunt_q <= hunt_next;
            end
`else
            state_q     <= RECEIVE;
            receiving_q <= 1'b1;
            stuff_err_q <= 1'b0;
            bit_cnt_q   <= BitCntW'(1);
            ones_cnt_q  <= OnesCntW'(serial_in_i);
`endif
          end
          RECEIVE: begin
            ones_cnt_q <= ones_next;
            if (bit_cnt_q == LastBit) begin
              rx_data_q    <= byte_asm;
              byte_valid_q <= 1'b1;
              bit_cnt_q    <= '0;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
            if (ones_next == StuffLimit) begin
              state_q <= STUFF;
            end
          end
          STUFF: begin
            if (!serial_in_i) begin
              ones_cnt_q <= '0;
              state_q    <= RECEIVE;
            end else begin
              stuff_err_q <= 1'b1;
              receiving_q <= 1'b0;
              state_q     <= ERROR;
            end
          end
          ERROR: begin
            // Wait for EOP; strobes are ignored.
          end
        endcase
      end
    end
  end

  assign rx_data_o    = rx_data_q;
  assign byte_valid_o = byte_valid_q;
  assign receiving_o  = receiving_q;
  assign stuff_err_o  = stuff_err_q;
  assign eop_err_o    = eop_err_q;

endmodule

// File: tb/tb_receive_shift.sv
module tb_receive_shift;

  logic       clk;
  logic       rst;
  logic       serial_in;
  logic       shift_strobe;
  logic       eop;
  logic [7:0] rx_data;
  logic       byte_valid;
  logic       receiving;
  logic       stuff_err;
  logic       eop_err;

  receive_shift dut (
    .clk            (clk),
    .rst            (rst),
    .serial_in_i    (serial_in),
    .shift_strobe_i (shift_strobe),
    .eop_i          (eop),
    .rx_data_o      (rx_data),
    .byte_valid_o   (byte_valid),
    .receiving_o    (receiving),
    .stuff_err_o    (stuff_err),
    .eop_err_o      (eop_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (packet-level view of the bit stream) ----------------
  localparam int Limit = 6;

  bit         m_in_packet;
  bit         m_in_error;
  bit         m_stuff_due;
  int         m_run;
  bit         m_bits[$];
  bit         m_hist[$];
  logic [7:0] q_byte[$];
  bit         q_ee[$];
  logic       exp_recv, exp_serr, exp_bv, exp_ee;
  logic [7:0] exp_rx;

  function automatic void model_reset();
    m_in_packet = 0; m_in_error = 0; m_stuff_due = 0; m_run = 0;
    m_bits.delete(); m_hist.delete(); q_byte.delete(); q_ee.delete();
    exp_recv = 0; exp_serr = 0; exp_bv = 0; exp_ee = 0; exp_rx = 8'h00;
  endfunction

  // Predicts the DUT outputs after the next clock edge for the given inputs.
  function automatic void model_step(input logic strb, input logic b, input logic e);
    int val;
    exp_bv = 0;
    exp_ee = 0;
    if (e) begin
      if (m_in_packet && m_bits.size() != 0) begin
        exp_ee = 1;
        q_ee.push_back(1'b1);
      end
      m_in_packet = 0; m_in_error = 0; m_stuff_due = 0; m_run = 0;
      m_bits.delete(); m_hist.delete();
      exp_recv = 0;
      return;
    end
    if (!strb || m_in_error) return;
    if (!m_in_packet) begin
`ifdef RX_SYNC_HUNT_EN
      bit is_sync;
      m_hist.push_back(b);
      if (m_hist.size() > 8) void'(m_hist.pop_front());
      is_sync = (m_hist.size() == 8) && m_hist[7];
      for (int i = 0; i < 7; i++) if (m_hist.size() == 8 && m_hist[i]) is_sync = 0;
      if (is_sync) begin
        m_in_packet = 1; exp_recv = 1; exp_serr = 0; m_run = 1;
        m_bits.delete(); m_hist.delete();
      end
      return;
`else
      m_in_packet = 1; exp_recv = 1; exp_serr = 0; m_run = 0;
      m_bits.delete();
`endif
    end
    if (m_stuff_due) begin
      m_stuff_due = 0;
      if (!b) begin
        m_run = 0;
      end else begin
        exp_serr = 1; exp_recv = 0; m_in_packet = 0; m_in_error = 1;
        m_bits.delete();
      end
      return;
    end
    m_run = b ? m_run + 1 : 0;
    m_bits.push_back(b);
    if (m_bits.size() == 8) begin
      val = 0;
      for (int i = 0; i < 8; i++) if (m_bits[i]) val += (1 << i);
      exp_rx = 8'(val);
      exp_bv = 1;
      q_byte.push_back(8'(val));
      m_bits.delete();
    end
    if (m_run == Limit) m_stuff_due = 1;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      chk("receiving", 32'(receiving), 32'(exp_recv));
      chk("stuff_err", 32'(stuff_err), 32'(exp_serr));
      chk("rx_data_held", 32'(rx_data), 32'(exp_rx));
      chk("byte_valid", 32'(byte_valid), 32'(exp_bv));
      chk("eop_err", 32'(eop_err), 32'(exp_ee));
      if (byte_valid) begin
        chk("byte_expected", 32'(q_byte.size() != 0), 32'd1);
        if (q_byte.size() != 0) chk("byte_data", 32'(rx_data), 32'(q_byte.pop_front()));
      end
      if (eop_err) begin
        chk("eop_err_expected", 32'(q_ee.size() != 0), 32'd1);
        if (q_ee.size() != 0) void'(q_ee.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  int enc_run;
  int max_gap;

  task automatic drive(input logic strb, input logic b, input logic e);
    shift_strobe = strb;
    serial_in    = b;
    eop          = e;
    model_step(strb, b, e);
    @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    int gap;
    gap = $urandom_range(max_gap, 0);
    repeat (gap) drive(1'b0, 1'($urandom_range(1, 0)), 1'b0);
    drive(1'b1, b, 1'b0);
  endtask

  // Sends a byte LSB-first with a stuff 0 inserted after each run of Limit ones.
  task automatic send_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) begin
      send_bit(v[i]);
      enc_run = v[i] ? enc_run + 1 : 0;
      if (enc_run == Limit) begin
        send_bit(1'b0);
        enc_run = 0;
      end
    end
  endtask

  task automatic start_packet();
`ifdef RX_SYNC_HUNT_EN
    for (int i = 0; i < 7; i++) send_bit(1'b0);
    send_bit(1'b1);
    enc_run = 1;
`else
    enc_run = 0;
`endif
  endtask

  task automatic end_packet();
    drive(1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0);
  endtask

  int kind;
  int nb;

  initial begin
    rst = 1'b1; serial_in = 1'b0; shift_strobe = 1'b0; eop = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_rx_data", 32'(rx_data), 32'd0);
    chk("reset_byte_valid", 32'(byte_valid), 32'd0);
    chk("reset_receiving", 32'(receiving), 32'd0);
    chk("reset_stuff_err", 32'(stuff_err), 32'd0);
    chk("reset_eop_err", 32'(eop_err), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Back-to-back strobes, then bytes with random gaps.
    max_gap = 0;
    start_packet(); send_byte(8'h80); send_byte(8'h55); end_packet();
    max_gap = 2;
    start_packet(); send_byte(8'hA5); end_packet();
    start_packet(); send_byte(8'hFF); send_byte(8'h3C); end_packet();

    // Stuff violation, ignored strobes in error, then a clean packet clears the flag.
    start_packet(); send_byte(8'h5A);
    repeat (7) send_bit(1'b1);
    repeat (3) drive(1'b1, 1'($urandom_range(1, 0)), 1'b0);
    end_packet();
    start_packet(); send_byte(8'hA5); end_packet();

    // Partial byte at EOP.
    start_packet(); send_byte(8'h12);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    end_packet();

    // EOP coincident with the completing strobe.
    start_packet(); send_byte(8'h34);
    for (int i = 0; i < 7; i++) send_bit(1'(i % 2));
    drive(1'b1, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 1'b0);

    // Asynchronous reset mid-byte.
    start_packet(); send_byte(8'h77);
    for (int i = 0; i < 4; i++) send_bit(1'(i % 2));
    shift_strobe = 1'b0;
    rst = 1'b1;
    model_reset();
    #1;
    chk("async_rst_rx_data", 32'(rx_data), 32'd0);
    chk("async_rst_byte_valid", 32'(byte_valid), 32'd0);
    chk("async_rst_receiving", 32'(receiving), 32'd0);
    chk("async_rst_stuff_err", 32'(stuff_err), 32'd0);
    chk("async_rst_eop_err", 32'(eop_err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Randomised packets.
    for (int p = 0; p < 60; p++) begin
      kind    = $urandom_range(3, 0);
      nb      = $urandom_range(3, 0);
      max_gap = $urandom_range(2, 0);
      start_packet();
      for (int k = 0; k < nb; k++) send_byte(8'($urandom));
      case (kind)
        1: repeat ($urandom_range(7, 1)) send_bit(1'($urandom_range(1, 0)));
        2: begin
          repeat (8) send_bit(1'b1);
          repeat (2) drive(1'b1, 1'($urandom_range(1, 0)), 1'b0);
        end
        3: drive(1'b1, 1'($urandom_range(1, 0)), 1'b1);
        default: ;
      endcase
      end_packet();
      repeat ($urandom_range(3, 0)) drive(1'b0, 1'($urandom_range(1, 0)), 1'b0);
      if ($urandom_range(3, 0) == 0) drive(1'b0, 1'b0, 1'b1);
    end

    repeat (4) drive(1'b0, 1'b0, 1'b0);
    chk("byte_queue_drained", 32'(q_byte.size()), 32'd0);
    chk("eop_err_queue_drained", 32'(q_ee.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
